logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single-bit combinational gate set.
- Applies one of eight bitwise operations to WIDTH-bit operands, selected per transaction.
- Optional accumulate mode replaces operand A with the most recent result.
- Two-stage valid/ready pipeline, with zero, all-ones and parity flags registered alongside the result.
- Sits between a command source and any consumer that needs gated/masked words.

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_op_core.sv | 35 +++
 rtl/logic_unit_pipe.sv | 111 +++++++++++
 tb/tb_logic_unit_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the registered logic unit and its combinational core.
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOTB  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational bitwise operation on two WIDTH-bit words, plus zero/ones/parity flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  // PASSA shares the default arm so the case is full for any tool.
  always_comb begin
    result = a;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_NOTB: result = ~b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: result = a;
    endcase
  end

  assign zero   = (result == '0);
  assign ones   = &result;
  assign parity = ^result;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_core with an optional accumulator as operand A.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             s1_acc;
  logic             s2_valid;
  logic [WIDTH-1:0] acc_reg;

  logic             s2_adv;
  logic             s1_adv;
  logic             s1_to_s2;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ones;
  logic             core_parity;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign s1_to_s2  = s1_valid && s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_valid && !rst;

  // In-order s2 capture means acc_reg always holds the previous command's result here.
  assign eff_a = s1_acc ? acc_reg : s1_a;

  logic_op_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (eff_a),
    .b      (in_b_unused_guard(s1_b)),
    .op     (s1_op),
    .result (core_result),
    .zero   (core_zero),
    .ones   (core_ones),
    .parity (core_parity)
  );

  function automatic logic [WIDTH-1:0] in_b_unused_guard(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_acc   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_acc <= in_acc;
      end
    end
  end

  // A clear coinciding with a transfer wins over loading the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
      acc_reg    <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= core_result;
          out_zero   <= core_zero;
          out_ones   <= core_ones;
          out_parity <= core_parity;
        end
      end
      if (acc_clr) begin
        acc_reg <= '0;
      end else if (s1_to_s2) begin
        acc_reg <= core_result;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, directed corner cases, random stream vs truth-table model.
module tb_logic_unit_pipe;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc;
  } cmd_t;

  typedef struct {
    cmd_t       c;
    logic [7:0] res;
    logic       z;
    logic       o;
    logic       p;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       o;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_acc, acc_clr;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       out_valid, out_ready, out_zero, out_ones, out_parity;
  logic [7:0] out_result;

  logic       w1_in_valid, w1_in_ready, w1_in_acc, w1_acc_clr;
  logic [0:0] w1_in_a, w1_in_b, w1_out_result;
  logic [2:0] w1_in_op;
  logic       w1_out_valid, w1_out_ready, w1_out_zero, w1_out_ones, w1_out_parity;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] model_acc = 8'h00;

  // Truth column per opcode, indexed by {a,b}
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                         4'b0101, 4'b0110, 4'b1001, 4'b1100};

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .in_op(w1_in_op), .in_acc(w1_in_acc), .acc_clr(w1_acc_clr),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready), .out_result(w1_out_result),
    .out_zero(w1_out_zero), .out_ones(w1_out_ones), .out_parity(w1_out_parity)
  );

  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] col;
    col = tt[op];
    for (int k = 0; k < 8; k++) r[k] = col[{a[k], b[k]}];
    return r;
  endfunction

  function automatic exp_t model_exp(input logic [7:0] r);
    exp_t e;
    e.res = r;
    e.z = (r == 8'h00);
    e.o = (r == 8'hFF);
    e.p = ($countones(r) % 2) == 1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input cmd_t c);
    in_valid = v;
    in_a     = c.a;
    in_b     = c.b;
    in_op    = c.op;
    in_acc   = c.acc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
    cmd_t c;
    c.op = op; c.a = a; c.b = b; c.acc = acc;
    return c;
  endfunction

  // mode 0: out_ready=1, mode 1: random valid/ready, mode 2: out_ready=0 for the first 5 cycles
  task automatic run_stream(input cmd_t cmds[$], input int mode, input string tag);
    exp_t expq[$];
    exp_t e;
    cmd_t idle;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int budget;
    logic held_v = 1'b0;
    logic [7:0] held_r = 8'h00;
    logic [7:0] ea;
    idle = mk(3'd0, 8'h00, 8'h00, 1'b0);
    budget = 20 * cmds.size() + 50;
    while (got < cmds.size() && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 99) < 70);
        default: out_ready = (cyc >= 5);
      endcase
      if (idx < cmds.size() && (mode != 1 || $urandom_range(0, 99) < 75))
        applyStimulus(1'b1, cmds[idx]);
      else
        applyStimulus(1'b0, idle);
      #1;
      if (mode == 2 && cyc >= 2 && cyc <= 4) checkOutput({tag, "_in_ready_full"}, in_ready, 1'b0);
      if (held_v) begin
        checkOutput({tag, "_stall_valid"}, out_valid, 1'b1);
        checkOutput({tag, "_stall_result"}, out_result, held_r);
      end
      if (in_valid && in_ready) begin
        ea = cmds[idx].acc ? model_acc : cmds[idx].a;
        e = model_exp(model_op(cmds[idx].op, ea, cmds[idx].b));
        model_acc = e.res;
        expq.push_back(e);
        idx++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput({tag, "_unexpected_output"}, 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          checkOutput({tag, "_result"}, out_result, e.res);
          checkOutput({tag, "_zero"}, out_zero, e.z);
          checkOutput({tag, "_ones"}, out_ones, e.o);
          checkOutput({tag, "_parity"}, out_parity, e.p);
        end
        got++;
      end
      held_v = out_valid && !out_ready;
      held_r = out_result;
      tick();
      cyc++;
    end
    if (got < cmds.size()) checkOutput({tag, "_timeout_outputs"}, got, cmds.size());
    applyStimulus(1'b0, idle);
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    vec_t vecs[$];
    cmd_t cq[$];
    cmd_t idle;
    logic [1:0] ab;
    logic [3:0] col;
    idle = mk(3'd0, 8'h00, 8'h00, 1'b0);

    for (int op = 0; op < 8; op++) vecs.push_back('{mk(3'(op), 8'hA5, 8'h3C, 1'b0), 8'h00, 1'b0, 1'b0, 1'b0});
    vecs[0].res = 8'h24; vecs[1].res = 8'hBD; vecs[2].res = 8'hDB; vecs[3].res = 8'h42;
    vecs[4].res = 8'hC3; vecs[5].res = 8'h99; vecs[6].res = 8'h66; vecs[7].res = 8'hA5;
    vecs.push_back('{mk(3'd5, 8'h5A, 8'h5A, 1'b0), 8'h00, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{mk(3'd6, 8'h5A, 8'h5A, 1'b0), 8'hFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{mk(3'd7, 8'h01, 8'h00, 1'b0), 8'h01, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{mk(3'd7, 8'hF0, 8'h00, 1'b0), 8'hF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{mk(3'd1, 8'h00, 8'h0F, 1'b1), 8'hFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{mk(3'd5, 8'h00, 8'hFF, 1'b1), 8'h00, 1'b1, 1'b0, 1'b0});

    applyStimulus(1'b0, idle);
    acc_clr = 1'b0; out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_in_op = 3'd0;
    w1_in_acc = 1'b0; w1_acc_clr = 1'b0; w1_out_ready = 1'b1;
    rst = 1'b1;
    tick();
    checkOutput("reset_in_ready", in_ready, 1'b0);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_reset_result", out_result, 8'h00);
    checkOutput("post_reset_in_ready", in_ready, 1'b1);

    $display("[TB] vector table, back-to-back");
    for (int j = 0; j < vecs.size() + 2; j++) begin
      if (j < vecs.size()) applyStimulus(1'b1, vecs[j].c);
      else applyStimulus(1'b0, idle);
      out_ready = 1'b1;
      #1;
      checkOutput("tbl_out_valid", out_valid, (j >= 2));
      if (j >= 2) begin
        checkOutput("tbl_result", out_result, vecs[j-2].res);
        checkOutput("tbl_zero", out_zero, vecs[j-2].z);
        checkOutput("tbl_ones", out_ones, vecs[j-2].o);
        checkOutput("tbl_parity", out_parity, vecs[j-2].p);
      end
      tick();
    end
    model_acc = vecs[vecs.size()-1].res;

    $display("[TB] backpressure");
    cq.delete();
    cq.push_back(mk(3'd0, 8'hF3, 8'h3F, 1'b0));
    cq.push_back(mk(3'd5, 8'h0F, 8'hFF, 1'b0));
    cq.push_back(mk(3'd1, 8'h00, 8'h81, 1'b1));
    cq.push_back(mk(3'd3, 8'h10, 8'h01, 1'b0));
    run_stream(cq, 2, "bp");

    $display("[TB] random stream");
    cq.delete();
    for (int i = 0; i < 150; i++)
      cq.push_back(mk(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0)));
    run_stream(cq, 1, "rnd");

    $display("[TB] acc_clr collision");
    tick();
    out_ready = 1'b1;
    applyStimulus(1'b1, mk(3'd7, 8'h11, 8'h00, 1'b0));
    tick();
    applyStimulus(1'b1, mk(3'd1, 8'h00, 8'h22, 1'b1));
    tick();
    applyStimulus(1'b1, mk(3'd7, 8'hFF, 8'h00, 1'b1));
    acc_clr = 1'b1;
    #1;
    checkOutput("clr_first_result", out_result, 8'h11);
    tick();
    acc_clr = 1'b0;
    applyStimulus(1'b0, idle);
    #1;
    checkOutput("clr_collide_valid", out_valid, 1'b1);
    checkOutput("clr_collide_result", out_result, 8'h33);
    tick();
    checkOutput("clr_after_result", out_result, 8'h00);
    checkOutput("clr_after_zero", out_zero, 1'b1);
    tick();
    model_acc = 8'h00;

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(1'b1, mk(3'd0, 8'hFF, 8'hFF, 1'b0));
    tick();
    applyStimulus(1'b1, mk(3'd1, 8'h12, 8'h34, 1'b0));
    tick();
    applyStimulus(1'b0, idle);
    #1;
    checkOutput("mid_full_in_ready", in_ready, 1'b0);
    checkOutput("mid_full_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("mid_after_valid", out_valid, 1'b0);
    checkOutput("mid_after_result", out_result, 8'h00);
    tick();
    checkOutput("mid_no_late_output", out_valid, 1'b0);
    model_acc = 8'h00;
    cq.delete();
    cq.push_back(mk(3'd1, 8'hAA, 8'h3C, 1'b1));
    cq.push_back(mk(3'd7, 8'h55, 8'h00, 1'b1));
    run_stream(cq, 0, "post_rst");

    $display("[TB] WIDTH=1 truth table");
    for (int j = 0; j < 34; j++) begin
      if (j < 32) begin
        ab = 2'(j % 4);
        w1_in_valid = 1'b1;
        w1_in_op = 3'(j / 4);
        w1_in_a = ab[1];
        w1_in_b = ab[0];
      end else begin
        w1_in_valid = 1'b0;
      end
      #1;
      checkOutput("w1_out_valid", w1_out_valid, (j >= 2));
      if (j >= 2) begin
        col = tt[(j-2) / 4];
        checkOutput("w1_result", w1_out_result, col[(j-2) % 4]);
        checkOutput("w1_parity", w1_out_parity, col[(j-2) % 4]);
        checkOutput("w1_zero", w1_out_zero, !col[(j-2) % 4]);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
